// File: rtl/mem_arbiter.sv
// Round-robin arbiter sharing one single-port word memory between N requesters.
// Each grant runs a fixed IDLE -> ACCESS -> DONE transaction with registered outputs.
module mem_arbiter #(
  parameter int N      = 2,
  parameter int addr_w = 32,
  parameter int data_w = 32
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [N-1:0]          req,
  input  logic [N-1:0]          we,
  input  logic [N*addr_w-1:0]   addr,
  input  logic [N*data_w-1:0]   wdata,
  output logic [N-1:0]          gnt,
  output logic [N-1:0]          done,
  output logic [data_w-1:0]     rdata,
  output logic [addr_w-1:0]     mem_addr,
  output logic [data_w-1:0]     mem_wdata,
  output logic                  mem_we,
  input  logic [data_w-1:0]     mem_rdata
);

  localparam int PW = (N > 1) ? $clog2(N) : 1;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_ACCESS = 2'd1,
    S_DONE   = 2'd2
  } state_t;

  state_t        state_r;
  logic [PW-1:0] ptr_r;
  logic [PW-1:0] win_r;
  logic [PW-1:0] win_s;
  logic [PW-1:0] ptr_next_s;
  logic          found_s;

  // Index reached k steps past base, wrapping at N (N need not be a power of two).
  function automatic logic [PW-1:0] rr_idx(input logic [PW-1:0] base, input int k);
    int s;
    s = (int'(base) + k) % N;
    return s[PW-1:0];
  endfunction

  // Round-robin winner search starting at the pointer.
  always_comb begin
    win_s   = ptr_r;
    found_s = 1'b0;
    for (int k = 0; k < N; k++) begin
      if (!found_s && req[rr_idx(ptr_r, k)]) begin
        found_s = 1'b1;
        win_s   = rr_idx(ptr_r, k);
      end else begin
        found_s = found_s;
      end
    end
    if (win_s == PW'(N - 1)) begin
      ptr_next_s = {PW{1'b0}};
    end else begin
      ptr_next_s = win_s + PW'(1'b1);
    end
  end

  // Transaction sequencer: accept in IDLE, drive memory in ACCESS, report in DONE.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r   <= S_IDLE;
      ptr_r     <= {PW{1'b0}};
      win_r     <= {PW{1'b0}};
      gnt       <= {N{1'b0}};
      done      <= {N{1'b0}};
      rdata     <= {data_w{1'b0}};
      mem_addr  <= {addr_w{1'b0}};
      mem_wdata <= {data_w{1'b0}};
      mem_we    <= 1'b0;
    end else begin
      case (state_r)
        S_IDLE: begin
          done <= {N{1'b0}};
          if (found_s) begin
            state_r   <= S_ACCESS;
            win_r     <= win_s;
            ptr_r     <= ptr_next_s;
            gnt       <= {{(N-1){1'b0}}, 1'b1} << win_s;
            mem_addr  <= addr[int'(win_s)*addr_w +: addr_w];
            mem_wdata <= wdata[int'(win_s)*data_w +: data_w];
            mem_we    <= we[win_s];
          end else begin
            state_r <= S_IDLE;
          end
        end
        S_ACCESS: begin
          // The memory commits on this same edge, so rdata is the pre-write word.
          rdata   <= mem_rdata;
          mem_we  <= 1'b0;
          gnt     <= {N{1'b0}};
          done    <= {{(N-1){1'b0}}, 1'b1} << win_r;
          state_r <= S_DONE;
        end
        S_DONE: begin
          done    <= {N{1'b0}};
          state_r <= S_IDLE;
        end
        default: begin
          gnt     <= {N{1'b0}};
          done    <= {N{1'b0}};
          mem_we  <= 1'b0;
          state_r <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter (N=4): directed scenarios plus random traffic, checked
// every cycle against a transaction-level schedule of expected events.
module tb_mem_arbiter;

  localparam int NR   = 4;
  localparam int AW   = 32;
  localparam int DW   = 32;
  localparam int MAXE = 4096;

  logic              clk = 1'b0;
  logic              reset;
  logic [NR-1:0]     req, we, gnt, done;
  logic [NR*AW-1:0]  addr;
  logic [NR*DW-1:0]  wdata;
  logic [DW-1:0]     rdata, mem_wdata, mem_rdata;
  logic [AW-1:0]     mem_addr;
  logic              mem_we;
  logic              init_mem;

  logic [DW-1:0]     mem [64];

  mem_arbiter #(.N(NR), .addr_w(AW), .data_w(DW)) dut (
    .clk(clk), .reset(reset), .req(req), .we(we), .addr(addr), .wdata(wdata),
    .gnt(gnt), .done(done), .rdata(rdata), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_we(mem_we), .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  assign mem_rdata = mem[mem_addr[5:0]];

  always @(posedge clk) begin
    if (init_mem) begin
      for (int i = 0; i < 64; i++) mem[i] <= 32'hA500_0000 | i;
    end else if (mem_we) begin
      mem[mem_addr[5:0]] <= mem_wdata;
    end
  end

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  int next_free = 0;
  int m_ptr = 0;
  bit rst_v;

  bit        pend [NR];
  bit        hold [NR];
  bit        a_we [NR];
  bit [31:0] a_addr [NR];
  bit [31:0] a_wd [NR];

  bit [31:0] ref_mem [64];

  bit            ev_acc [MAXE];
  bit            ev_rst [MAXE];
  bit            ev_dv  [MAXE];
  bit            ev_we  [MAXE];
  bit [NR-1:0]   ev_gnt [MAXE];
  bit [NR-1:0]   ev_done[MAXE];
  bit [31:0]     ev_addr[MAXE];
  bit [31:0]     ev_wd  [MAXE];
  bit [31:0]     ev_rd  [MAXE];
  bit [31:0]     x_addr = 32'd0, x_wd = 32'd0, x_rd = 32'd0;

  int gq[$];
  int gc[$];

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s cycle=%0d got=%0h exp=%0h", tag, cyc, got, exp);
    end
  endtask

  task automatic clear_ev(input int k);
    ev_acc[k] = 1'b0; ev_rst[k] = 1'b0; ev_dv[k] = 1'b0; ev_we[k] = 1'b0;
    ev_gnt[k] = '0; ev_done[k] = '0;
  endtask

  // Decide what edge e does, from the request rules, and schedule its visible effects.
  task automatic model(input int e);
    int w;
    int j;
    if (rst_v) begin
      for (int k = e; k < e + 3; k++) clear_ev(k);
      ev_rst[e] = 1'b1;
      m_ptr     = 0;
      next_free = e + 1;
    end else begin
      w = -1;
      if (e >= next_free) begin
        for (int k = 0; k < NR; k++) begin
          j = (m_ptr + k) % NR;
          if (w < 0 && pend[j]) w = j;
        end
      end
      if (w >= 0) begin
        ev_acc[e]    = 1'b1;
        ev_gnt[e]    = 4'b0001 << w;
        ev_we[e]     = a_we[w];
        ev_addr[e]   = a_addr[w];
        ev_wd[e]     = a_wd[w];
        ev_dv[e+1]   = 1'b1;
        ev_done[e+1] = 4'b0001 << w;
        ev_rd[e+1]   = ref_mem[a_addr[w][5:0]];
        if (a_we[w]) ref_mem[a_addr[w][5:0]] = a_wd[w];
        m_ptr     = (w + 1) % NR;
        next_free = e + 3;
      end
    end
  endtask

  task automatic compare(input int e);
    if (ev_rst[e]) begin x_addr = 32'd0; x_wd = 32'd0; x_rd = 32'd0; end
    if (ev_acc[e]) begin x_addr = ev_addr[e]; x_wd = ev_wd[e]; end
    if (ev_dv[e])  x_rd = ev_rd[e];
    check("gnt",       64'(gnt),       64'(ev_gnt[e]));
    check("done",      64'(done),      64'(ev_done[e]));
    check("mem_we",    64'(mem_we),    64'(ev_we[e]));
    check("mem_addr",  64'(mem_addr),  64'(x_addr));
    check("mem_wdata", 64'(mem_wdata), 64'(x_wd));
    check("rdata",     64'(rdata),     64'(x_rd));
  endtask

  task automatic step();
    @(negedge clk);
    reset = rst_v;
    for (int i = 0; i < NR; i++) begin
      req[i] = pend[i];
      we[i]  = a_we[i];
      addr[i*AW +: AW]  = a_addr[i];
      wdata[i*DW +: DW] = a_wd[i];
    end
    model(cyc);
    @(posedge clk);
    #1;
    compare(cyc);
    for (int i = 0; i < NR; i++) begin
      if (gnt[i] === 1'b1) begin
        gq.push_back(i);
        gc.push_back(cyc);
        if (!hold[i]) pend[i] = 1'b0;
      end
    end
    cyc++;
  endtask

  task automatic set_req(input int i, input bit w, input bit [31:0] a, input bit [31:0] d);
    pend[i] = 1'b1; a_we[i] = w; a_addr[i] = a; a_wd[i] = d;
  endtask

  task automatic wait_gnt(input int i, input string tag);
    int n = 0;
    while (gnt[i] !== 1'b1 && n < 20) begin step(); n++; end
    check(tag, 64'(gnt[i]), 64'd1);
  endtask

  task automatic wait_done(input int i, input string tag);
    int n = 0;
    while (done[i] !== 1'b1 && n < 20) begin step(); n++; end
    check(tag, 64'(done[i]), 64'd1);
  endtask

  task automatic do_reset();
    rst_v = 1'b1; step(); rst_v = 1'b0;
    gq.delete(); gc.delete();
  endtask

  initial begin
    int exp_ord[8];
    for (int i = 0; i < 64; i++) ref_mem[i] = 32'hA500_0000 | i;
    for (int i = 0; i < NR; i++) begin
      pend[i] = 1'b0; hold[i] = 1'b0; a_we[i] = 1'b0; a_addr[i] = 32'd0; a_wd[i] = 32'd0;
    end
    init_mem = 1'b1;
    rst_v = 1'b1;
    step();
    init_mem = 1'b0;
    step();
    rst_v = 1'b0;

    // Idle after reset.
    repeat (10) step();

    // Write then read back 0x10 from requester 0.
    set_req(0, 1'b1, 32'h10, 32'hDEAD_BEEF);
    wait_gnt(0, "w10_gnt");
    check("w10_we", 64'(mem_we), 64'd1);
    wait_done(0, "w10_done");
    check("rd_old", 64'(rdata), 64'hA500_0010);
    set_req(0, 1'b0, 32'h10, 32'd0);
    wait_gnt(0, "r10_gnt");
    wait_done(0, "r10_done");
    check("rd_10", 64'(rdata), 64'hDEAD_BEEF);

    // Two requesters held high: alternating grants, three cycles apart.
    do_reset();
    for (int i = 0; i < 2; i++) begin set_req(i, 1'b0, 32'(i), 32'd0); hold[i] = 1'b1; end
    repeat (12) step();
    for (int i = 0; i < 2; i++) begin hold[i] = 1'b0; pend[i] = 1'b0; end
    check("alt_n", 64'(gq.size()), 64'd4);
    for (int j = 0; j < 4 && j < gq.size(); j++) check("alt_ord", 64'(gq[j]), 64'(j % 2));
    for (int j = 0; j < 3 && j + 1 < gc.size(); j++) check("alt_gap", 64'(gc[j+1] - gc[j]), 64'd3);
    repeat (3) step();

    // req=1010 then 1111.
    do_reset();
    set_req(1, 1'b0, 32'h1, 32'd0); hold[1] = 1'b1;
    set_req(3, 1'b0, 32'h3, 32'd0); hold[3] = 1'b1;
    repeat (12) step();
    for (int i = 0; i < NR; i++) begin set_req(i, 1'b0, 32'(i + 8), 32'd0); hold[i] = 1'b1; end
    repeat (12) step();
    for (int i = 0; i < NR; i++) begin hold[i] = 1'b0; pend[i] = 1'b0; end
    exp_ord = '{1, 3, 1, 3, 0, 1, 2, 3};
    check("rr_n", 64'(gq.size()), 64'd8);
    for (int j = 0; j < 8 && j < gq.size(); j++) check("rr_ord", 64'(gq[j]), 64'(exp_ord[j]));
    repeat (3) step();

    // Reset during the ACCESS cycle of a write: write lands, no done, ptr back to 0.
    do_reset();
    set_req(0, 1'b1, 32'h20, 32'h55);
    wait_gnt(0, "w20_gnt");
    rst_v = 1'b1; step(); rst_v = 1'b0;
    check("rst_we", 64'(mem_we), 64'd0);
    check("rst_done", 64'(done), 64'd0);
    step();
    check("rst_done2", 64'(done), 64'd0);
    set_req(0, 1'b0, 32'h20, 32'd0);
    set_req(1, 1'b0, 32'h00, 32'd0);
    wait_gnt(0, "ptr_rst");
    check("ptr_rst_gnt", 64'(gnt), 64'd1);
    wait_done(0, "r20_done");
    check("rd_20", 64'(rdata), 64'h55);
    wait_done(1, "r00_done");
    repeat (2) step();

    // Request raised during another transaction's ACCESS cycle.
    gq.delete(); gc.delete();
    set_req(0, 1'b0, 32'h5, 32'd0);
    wait_gnt(0, "late_g0");
    set_req(1, 1'b0, 32'h6, 32'd0);
    wait_gnt(1, "late_g1");
    check("late_n", 64'(gc.size()), 64'd2);
    if (gc.size() == 2) check("late_gap", 64'(gc[1] - gc[0]), 64'd3);
    repeat (3) step();

    // Random traffic with occasional resets.
    for (int t = 0; t < 1500; t++) begin
      for (int i = 0; i < NR; i++) begin
        if (!pend[i] && ($urandom % 3 == 0))
          set_req(i, 1'($urandom % 2), 32'($urandom_range(0, 63)), $urandom);
      end
      rst_v = ($urandom % 150 == 0);
      step();
    end
    rst_v = 1'b0;
    for (int i = 0; i < NR; i++) pend[i] = 1'b0;
    repeat (4) step();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Round-robin arbiter that shares the single-port word memory between N requesters, typically instruction fetch and data load/store in the processor. Each accepted request becomes one three-cycle memory transaction. The arbiter registers the address, write data and write enable, drives the memory port for one cycle, then returns read data with a one-cycle done pulse. It sits between the requesters and the memory; the memory writes only when `mem_we` is high.

## Interface
- `N`, 2: number of requesters; legal range 2..8.
- `addr_w`, 32: address width.
- `data_w`, 32: data width.

- `clk`  in  1: clock; all state updates on the rising edge.
- `reset`  in  1: synchronous, active-high.
- `req`  in  N: request level, one bit per requester.
- `we`  in  N: 1 = write, 0 = read; qualified by `req`.
- `addr`  in  N*addr_w: requester i's address is at bits `[i*addr_w +: addr_w]`.
- `wdata`  in  N*data_w: requester i's write data is at bits `[i*data_w +: data_w]`.
- `gnt`  out  N: one-hot, one-cycle pulse marking the request as accepted.
- `done`  out  N: one-hot, one-cycle pulse marking the transaction complete.
- `rdata`  out  data_w: memory word for the completed transaction; valid only while `done` is nonzero.
- `mem_addr`  out  addr_w: memory address.
- `mem_wdata`  out  data_w: memory write data.
- `mem_we`  out  1: memory write enable.
- `mem_rdata`  in  data_w: combinational read data from the memory.

## Operation
- FSM states and transitions:
  - IDLE to ACCESS when any `req` bit is set.
  - ACCESS to DONE unconditionally.
  - DONE to IDLE unconditionally.
- Request sampling:
  - `req`, `we`, `addr` and `wdata` are sampled only at the edge that leaves IDLE.
  - Requests asserted in ACCESS or DONE wait until the next IDLE cycle.
- Arbitration: round-robin pointer `ptr` (0..N-1).
  - The winner is the first set `req` bit found scanning `ptr, ptr+1, …, N-1, 0, …` modulo N.
  - On acceptance, `ptr` becomes (winner+1) mod N.
- On acceptance, these are registered:
  - winner index
  - `mem_addr` set to the winner's `addr`
  - `mem_wdata` set to the winner's `wdata`
  - `mem_we` set to the winner's `we`
  - `gnt[winner]` set to 1
- ACCESS:
  - `mem_*` outputs are stable.
  - `mem_we` high commits the write at the edge ending ACCESS.
  - `mem_rdata` is captured into the `rdata` register at that same edge.
  - At that edge, `mem_we` and `gnt` clear to 0. `mem_addr` and `mem_wdata` hold their values.
- DONE:
  - `done[winner]` is 1 and `rdata` holds the captured word.
  - For a write, `rdata` is the word at `mem_addr` before the write.
- Requester obligations:
  - Hold `req`, `we`, `addr` and `wdata` stable until the cycle `gnt` is seen.
  - After that, the requester may change them freely.
  - A `req` still high in the next IDLE cycle starts a new transaction.
- Reset values: FSM in IDLE; all of the following are 0:
  - `ptr`, `gnt`, `done`, `rdata`
  - `mem_addr`, `mem_wdata`, `mem_we`
- Reset mid-operation:
  - All registers return to their reset values at the edge; no `done` pulse is issued.
  - If reset is asserted during an ACCESS cycle with `mem_we`=1, the write still commits at that edge. The memory sees the registered `mem_we`, which is cleared only after that edge.
- Simultaneous requests from all N: each requester is served exactly once per N transactions.

## Timing
- Cycle T (IDLE): `req` sampled.
- T+1 (ACCESS): `gnt` pulse; `mem_*` driven; write commits at the end of T+1.
- T+2 (DONE): `done` pulse with `rdata` valid.
- T+3: IDLE, ready to accept the next request.
- Latency from request to done is 2 cycles.
- Peak throughput is one transaction per 3 cycles.
- All outputs are registered; no combinational path runs from `req` to `gnt`, `done` or `mem_*`.
- `mem_rdata` is used only at the edge that ends ACCESS.

## Test plan
- Reset, then `req`=0 for 10 cycles -> `gnt`=`done`=`mem_we`=0 and `mem_addr`=0 every cycle.
- Requester 0 writes `addr`=0x10, `wdata`=0xDEADBEEF at T, then reads 0x10 -> first transaction:
  - `gnt[0]` and `mem_we`=1 at T+1;
  - `done[0]` at T+2 with `rdata` = old content.
  - Second transaction: `done[0]` with `rdata`=0xDEADBEEF.
- N=2, both `req` held high for 12 cycles -> grants alternate 0,1,0,1; `done` follows each `gnt` by 1 cycle; IDLE cycles at T+3, T+6, ….
- N=4, after reset `req`=4'b1010 held -> grant order 1,3,1,3; then `req`=4'b1111 with `ptr`=0 -> order 0,1,2,3.
- Reset asserted in the ACCESS cycle of a write of 0x55 to 0x20 -> no `done`; next cycle has `mem_we`=0 and `ptr`=0; a subsequent read of 0x20 returns 0x55.
- `req` raised during ACCESS of another transaction -> not sampled until the following IDLE; its `gnt` appears exactly 3 cycles after the prior `gnt`.
